// File: rtl/ama_riscv_reg_file_sb_if.sv
// Register file / scoreboard bus.
// Groups the writeback port, the read ports, the issue port and the
// scoreboard status outputs of ama_riscv_reg_file_sb.
//   master : decode/writeback side (drives requests, observes read data/status)
//   slave  : the register file itself
// Signals:
//   we, addr_d, data_d  writeback write enable / destination / data
//   rd_addr, rd_data    packed read addresses / read data, port i at slice i
//   rd_busy             per-port "operand still in flight" flag
//   issue_v, issue_rd   instruction issued with destination issue_rd
//   pending_cnt         number of registers marked pending
//   any_pending         pending_cnt != 0
interface ama_riscv_reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS);

  logic                we;
  logic [AW-1:0]       addr_d;
  logic [XLEN-1:0]     data_d;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                issue_v;
  logic [AW-1:0]       issue_rd;
  logic [CW-1:0]       pending_cnt;
  logic                any_pending;

  modport master (
    output we, addr_d, data_d, rd_addr, issue_v, issue_rd,
    input  rd_data, rd_busy, pending_cnt, any_pending
  );

  modport slave (
    input  we, addr_d, data_d, rd_addr, issue_v, issue_rd,
    output rd_data, rd_busy, pending_cnt, any_pending
  );
endinterface

// File: rtl/ama_riscv_reg_file_sb.sv
// Integer register file with integrated pending-write scoreboard.
// NRD combinational read ports with same-cycle writeback bypass, one
// synchronous write port, and a per-register pending bit set on issue and
// cleared on writeback so decode can stall on RAW hazards.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset (clears array, scoreboard, count)
//   bus    ama_riscv_reg_file_sb_if.slave (write, read, issue, status)
module ama_riscv_reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ama_riscv_reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS);

  // Entry 0 is held at zero and never read, so it reduces to constants.
  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [AW-1:0]    ra [NRD];
  logic             wr_hit;
  logic             set_hit;
  logic             inc;
  logic             dec;

  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign ra[g] = bus.rd_addr[g*AW +: AW];
  end

  assign wr_hit  = bus.we && (bus.addr_d != '0);
  assign set_hit = bus.issue_v && (bus.issue_rd != '0);

  // Count moves only on a real 0->1 or 1->0 transition. A set and clear of
  // the same register leaves it pending, so that case is never a decrement.
  assign inc = set_hit && !pending[bus.issue_rd];
  assign dec = wr_hit && pending[bus.addr_d] &&
               !(set_hit && (bus.issue_rd == bus.addr_d));

  always_comb begin
    pending_nxt = pending;
    if (wr_hit)  pending_nxt[bus.addr_d]   = 1'b0;
    // Set applied after clear: the issued producer is younger.
    if (set_hit) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;

    cnt_nxt = cnt;
    if (inc && !dec)      cnt_nxt = cnt + CW'(1);
    else if (dec && !inc) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      pending <= '0;
      cnt     <= '0;
    end else begin
      rf[0] <= '0;
      if (wr_hit) rf[bus.addr_d] <= bus.data_d;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write bypasses the array and
  // also resolves the pending hazard for that operand.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i] != '0) begin
        if (bus.we && (bus.addr_d == ra[i])) begin
          bus.rd_data[i*XLEN +: XLEN] = bus.data_d;
        end else begin
          bus.rd_data[i*XLEN +: XLEN] = rf[ra[i]];
          bus.rd_busy[i]              = pending[ra[i]];
        end
      end
    end
  end

  assign bus.pending_cnt = cnt;
  assign bus.any_pending = (cnt != '0);
endmodule

// File: tb/tb_ama_riscv_reg_file_sb.sv
module tb_ama_riscv_reg_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ama_riscv_reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  ama_riscv_reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd_data[63:32];
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.addr_d = '0; bus.data_d = '0;
    bus.rd_addr = '0; bus.issue_v = 1'b0; bus.issue_rd = '0;
    step(); step();
    rst_n = 1'b1;
    settle();
    chk("post_reset_rd0", rd0(), 32'h0);
    chk("post_reset_cnt", 32'(bus.pending_cnt), 32'd0);

    // Reset clears data and scoreboard; reset beats simultaneous write/issue
    bus.we = 1'b1; bus.addr_d = 5; bus.data_d = 32'hDEADBEEF;
    bus.issue_v = 1'b1; bus.issue_rd = 5;
    rd(5, 5);
    settle();
    chk("x5_bypass", rd0(), 32'hDEADBEEF);
    step();
    bus.we = 1'b0; bus.issue_v = 1'b0;
    settle();
    chk("x5_array", rd1(), 32'hDEADBEEF);
    chk("x5_set_clr_busy", 32'(bus.rd_busy[0]), 32'd1);
    chk("x5_set_clr_cnt", 32'(bus.pending_cnt), 32'd1);
    rst_n = 1'b0;
    bus.we = 1'b1; bus.addr_d = 6; bus.data_d = 32'h55;
    bus.issue_v = 1'b1; bus.issue_rd = 6;
    step();
    rst_n = 1'b1; bus.we = 1'b0; bus.issue_v = 1'b0;
    rd(5, 6);
    settle();
    chk("rst_x5", rd0(), 32'h0);
    chk("rst_x6", rd1(), 32'h0);
    chk("rst_busy", 32'(bus.rd_busy), 32'd0);
    chk("rst_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("rst_any", 32'(bus.any_pending), 32'd0);

    // x0 is never written, never pending
    bus.we = 1'b1; bus.addr_d = 0; bus.data_d = 32'hFFFFFFFF;
    bus.issue_v = 1'b1; bus.issue_rd = 0;
    rd(0, 0);
    settle();
    chk("x0_rd0_wr", rd0(), 32'h0);
    chk("x0_rd1_wr", rd1(), 32'h0);
    chk("x0_busy_wr", 32'(bus.rd_busy), 32'd0);
    step();
    bus.we = 1'b0; bus.issue_v = 1'b0;
    settle();
    chk("x0_rd0_after", rd0(), 32'h0);
    chk("x0_cnt_after", 32'(bus.pending_cnt), 32'd0);

    // Bypass on both ports, then array read
    bus.we = 1'b1; bus.addr_d = 7; bus.data_d = 32'h12345678;
    rd(7, 7);
    settle();
    chk("byp_p0", rd0(), 32'h12345678);
    chk("byp_p1", rd1(), 32'h12345678);
    step();
    bus.we = 1'b0;
    settle();
    chk("arr_p0", rd0(), 32'h12345678);
    chk("arr_p1", rd1(), 32'h12345678);

    // Scoreboard set / bypass-resolved clear
    bus.issue_v = 1'b1; bus.issue_rd = 3;
    rd(3, 7);
    step();
    bus.issue_v = 1'b0;
    settle();
    chk("sb_busy_x3", 32'(bus.rd_busy[0]), 32'd1);
    chk("sb_busy_x7", 32'(bus.rd_busy[1]), 32'd0);
    chk("sb_cnt1", 32'(bus.pending_cnt), 32'd1);
    chk("sb_any1", 32'(bus.any_pending), 32'd1);
    step(); step(); step();
    chk("sb_busy_hold", 32'(bus.rd_busy[0]), 32'd1);
    bus.we = 1'b1; bus.addr_d = 3; bus.data_d = 32'hA5A50003;
    settle();
    chk("sb_wb_busy", 32'(bus.rd_busy[0]), 32'd0);
    chk("sb_wb_data", rd0(), 32'hA5A50003);
    chk("sb_wb_cnt", 32'(bus.pending_cnt), 32'd1);
    step();
    bus.we = 1'b0;
    settle();
    chk("sb_after_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("sb_after_busy", 32'(bus.rd_busy[0]), 32'd0);
    chk("sb_after_data", rd0(), 32'hA5A50003);

    // Simultaneous set and clear
    bus.issue_v = 1'b1; bus.issue_rd = 9;
    step();
    bus.we = 1'b1; bus.addr_d = 9; bus.data_d = 32'h9;
    rd(10, 9);
    settle();
    chk("sim_byp_busy", 32'(bus.rd_busy[1]), 32'd0);
    step();
    bus.we = 1'b0; bus.issue_v = 1'b0;
    settle();
    chk("sim_x9_busy", 32'(bus.rd_busy[1]), 32'd1);
    chk("sim_cnt_same", 32'(bus.pending_cnt), 32'd1);
    bus.issue_v = 1'b1; bus.issue_rd = 10;
    bus.we = 1'b1; bus.addr_d = 9; bus.data_d = 32'h99;
    step();
    bus.we = 1'b0; bus.issue_v = 1'b0;
    settle();
    chk("sim2_cnt", 32'(bus.pending_cnt), 32'd1);
    chk("sim2_x10_busy", 32'(bus.rd_busy[0]), 32'd1);
    chk("sim2_x9_busy", 32'(bus.rd_busy[1]), 32'd0);
    chk("sim2_x9_data", rd1(), 32'h99);
    bus.we = 1'b1; bus.addr_d = 10; bus.data_d = 32'h10;
    step();
    // Clear of a non-pending register must not decrement
    bus.addr_d = 12; bus.data_d = 32'hC;
    step();
    bus.we = 1'b0;
    settle();
    chk("nonpend_clr_cnt", 32'(bus.pending_cnt), 32'd0);

    // Fill the scoreboard
    for (int i = 1; i < NREGS; i++) begin
      bus.issue_v = 1'b1; bus.issue_rd = AW'(i);
      step();
    end
    bus.issue_v = 1'b0;
    settle();
    chk("fill_cnt", 32'(bus.pending_cnt), 32'(NREGS - 1));
    bus.issue_v = 1'b1; bus.issue_rd = 4;
    step();
    bus.issue_v = 1'b0;
    settle();
    chk("fill_reissue_cnt", 32'(bus.pending_cnt), 32'(NREGS - 1));
    for (int i = 1; i < NREGS; i++) begin
      bus.we = 1'b1; bus.addr_d = AW'(i); bus.data_d = 32'(i) * 32'h01010101;
      step();
    end
    bus.we = 1'b0;
    rd(31, 4);
    settle();
    chk("drain_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("drain_any", 32'(bus.any_pending), 32'd0);
    chk("drain_x31", rd0(), 32'h1F1F1F1F);
    chk("drain_x4", rd1(), 32'h04040404);

    // Mid-operation reset discards pending marks
    bus.issue_v = 1'b1; bus.issue_rd = 8;
    step();
    bus.issue_v = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.we = 1'b1; bus.addr_d = 8; bus.data_d = 32'h88;
    step();
    bus.we = 1'b0;
    rd(8, 31);
    settle();
    chk("midrst_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("midrst_any", 32'(bus.any_pending), 32'd0);
    chk("midrst_x8", rd0(), 32'h88);
    chk("midrst_x31", rd1(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ama_riscv_reg_file_sb.md
# ama_riscv_reg_file_sb

Parametrised integer register file with N asynchronous read ports, one synchronous write port, same-cycle write-to-read bypass, synchronous clearing reset and an integrated per-register pending-write scoreboard. It sits in the decode stage of the core: read ports feed operand muxes, the write port is driven by writeback, and the issue port marks destination registers as in-flight so decode can stall on RAW hazards without an external hazard unit.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (x0 included, power of 2, >= 2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), derived address width; not overridden
- CW, $clog2(NREGS), derived width of pending_cnt; not overridden

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- we  in  1  writeback write enable
- addr_d  in  AW  writeback destination
- data_d  in  XLEN  writeback data
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i operand has an outstanding write not resolved this cycle
- issue_v  in  1  instruction issued with a register destination
- issue_rd  in  AW  destination of issued instruction
- pending_cnt  out  CW  number of registers currently marked pending
- any_pending  out  1  pending_cnt != 0

## Operation
- Storage: registers 1..NREGS-1 of XLEN bits; x0 has no storage.
- Write: at posedge, if rst_n=1, we=1 and addr_d!=0, rf[addr_d] <= data_d. Writes to x0 are dropped.
- Read port i (combinational, independent per port):
  - rd_addr_i==0 -> 0.
  - else if we=1 and addr_d==rd_addr_i -> data_d (bypass; the same-cycle write wins over the array).
  - else -> rf[rd_addr_i].
- Scoreboard: pending[NREGS-1:1], pending[0] hard-wired 0.
  - set: issue_v=1 and issue_rd!=0 -> pending[issue_rd] <= 1.
  - clear: we=1 and addr_d!=0 -> pending[addr_d] <= 0.
  - same register set and cleared in one cycle -> ends pending=1 (the issued producer is younger than the retiring one).
  - set of an already-pending register -> remains 1; no count increment.
  - clear of a non-pending register -> no effect; no count decrement.
- rd_busy[i] = pending[rd_addr_i] & ~(we & addr_d==rd_addr_i); rd_addr_i==0 -> 0. Bypass resolves the hazard in the writeback cycle.
- pending_cnt: registered; updated each cycle by +1 (new set only), -1 (real clear only), 0 (both or neither); always equals popcount(pending). Maximum NREGS-1, no wrap possible.
- any_pending: combinational from pending_cnt.

## Timing
- Read latency 0 cycles (combinational from rd_addr, we, addr_d, data_d).
- Written value returned from the array from the cycle after the write edge; via bypass in the write cycle itself.
- Scoreboard set visible on rd_busy the cycle after issue_v.
- Reset (rst_n=0 sampled at posedge): all rf entries <= 0, pending <= 0, pending_cnt <= 0. During the reset cycle we and issue_v are ignored; reset wins over simultaneous write/issue.
- Outputs after reset: rd_data = 0 on all ports (with we=0), rd_busy = 0, pending_cnt = 0, any_pending = 0.
- Reset asserted mid-operation discards all in-flight pending marks; a later writeback to a formerly pending register is a no-op clear.
- No X propagation: unused reads of x0 return 0 regardless of array contents.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rst_n=0 one cycle -> rd_data for x5 reads 0, pending_cnt=0, any_pending=0.
- x0: we=1, addr_d=0, data_d=0xFFFFFFFF, issue_v=1, issue_rd=0 -> all ports reading x0 return 0, rd_busy=0, pending_cnt unchanged.
- Bypass: cycle N we=1 addr_d=7 data_d=0x12345678, port 0 and port 1 both read x7 -> both return 0x12345678 in cycle N; cycle N+1 with we=0 still 0x12345678.
- Scoreboard: issue x3 at cycle N -> rd_busy for x3 =1 at N+1, pending_cnt=1; writeback x3 at N+4 -> rd_busy=0 in N+4 (bypass) and data correct; pending_cnt=0 at N+5.
- Simultaneous: x9 pending, same cycle issue_v x9 and we x9 -> x9 stays pending, pending_cnt unchanged; issue x10 and writeback x9 -> pending_cnt unchanged, x9 clear, x10 pending.
- Fill: issue x1..x(NREGS-1) consecutively -> pending_cnt=NREGS-1, re-issue x4 -> still NREGS-1; write back all -> 0, any_pending=0.
